// File: rtl/if_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: program counter, instruction-memory
// handshake, one-entry stall buffer and the IF/ID pipeline register.
module if_fetch_stage #(
   parameter int                    WORDLENGTH = 32,
   parameter logic [WORDLENGTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            Branch_taken,
   input  logic                  Flush,
   input  logic [WORDLENGTH-1:0] br_target,
   input  logic [WORDLENGTH-1:0] jump_target,
   input  logic                  Stall,
   output logic                  imem_req,
   output logic [WORDLENGTH-1:0] imem_addr,
   input  logic [WORDLENGTH-1:0] imem_rdata,
   input  logic                  imem_ready,
   output logic [WORDLENGTH-1:0] PC,
   output logic [WORDLENGTH-1:0] IF_ID_instr,
   output logic [WORDLENGTH-1:0] IF_ID_pc4,
   output logic                  IF_ID_valid
);

   typedef enum logic {FETCH, HOLD} state_t;

   state_t                r_state, w_state_nxt;
   logic [WORDLENGTH-1:0] r_pc, w_pc_nxt;
   logic [WORDLENGTH-1:0] r_ibuf, w_ibuf_nxt;
   logic [WORDLENGTH-1:0] r_instr, w_instr_nxt;
   logic [WORDLENGTH-1:0] r_pc4, w_pc4_nxt;
   logic                  r_valid, w_valid_nxt;
   logic [WORDLENGTH-1:0] w_pc_plus4;
   logic [WORDLENGTH-1:0] w_target;
   logic                  w_redirect;

   assign w_pc_plus4 = r_pc + WORDLENGTH'(4);
   assign w_redirect = (Branch_taken == 2'b01) || (Branch_taken == 2'b10);
   assign w_target   = Branch_taken[0] ? br_target : jump_target;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ibuf_nxt  = r_ibuf;
      w_instr_nxt = r_instr;
      w_pc4_nxt   = r_pc4;
      w_valid_nxt = r_valid;
      if (w_redirect) begin
         w_pc_nxt    = w_target;
         w_state_nxt = FETCH;
         w_ibuf_nxt  = '0;
         // The instruction fetched this cycle is on the wrong path; drop it.
         if (Flush || !Stall) begin
            w_instr_nxt = '0;
            w_valid_nxt = 1'b0;
         end
      end else if (Flush) begin
         // PC holds so the current address is simply fetched again.
         w_state_nxt = FETCH;
         w_ibuf_nxt  = '0;
         w_instr_nxt = '0;
         w_valid_nxt = 1'b0;
      end else begin
         unique case (r_state)
            FETCH: begin
               if (imem_ready) begin
                  if (Stall) begin
                     w_ibuf_nxt  = imem_rdata;
                     w_state_nxt = HOLD;
                  end else begin
                     w_instr_nxt = imem_rdata;
                     w_pc4_nxt   = w_pc_plus4;
                     w_valid_nxt = 1'b1;
                     w_pc_nxt    = w_pc_plus4;
                  end
               end else if (!Stall) begin
                  w_instr_nxt = '0;
                  w_valid_nxt = 1'b0;
               end
            end
            HOLD: begin
               if (!Stall) begin
                  w_instr_nxt = r_ibuf;
                  w_pc4_nxt   = w_pc_plus4;
                  w_valid_nxt = 1'b1;
                  w_pc_nxt    = w_pc_plus4;
                  w_state_nxt = FETCH;
               end
            end
            default: w_state_nxt = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FETCH;
         r_pc    <= RESET_PC;
         r_ibuf  <= '0;
         r_instr <= '0;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_ibuf  <= w_ibuf_nxt;
         r_instr <= w_instr_nxt;
         r_pc4   <= w_pc4_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   assign imem_req    = !rst && (r_state == FETCH);
   assign imem_addr   = r_pc;
   assign PC          = r_pc;
   assign IF_ID_instr = r_instr;
   assign IF_ID_pc4   = r_pc4;
   assign IF_ID_valid = r_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random traffic checked
// against a queue-based model of the fetch stream.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  Branch_taken;
   logic        Flush;
   logic [31:0] br_target, jump_target;
   logic        Stall;
   logic        imem_req;
   logic [31:0] imem_addr, imem_rdata;
   logic        imem_ready;
   logic [31:0] PC, IF_ID_instr, IF_ID_pc4;
   logic        IF_ID_valid;

   int checks = 0;
   int failures = 0;

   // reference model
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;
   logic [31:0] m_buf[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   assign imem_rdata = mem(imem_addr);

   if_fetch_stage #(.WORDLENGTH(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .Branch_taken(Branch_taken), .Flush(Flush),
      .br_target(br_target), .jump_target(jump_target), .Stall(Stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_ready(imem_ready), .PC(PC), .IF_ID_instr(IF_ID_instr),
      .IF_ID_pc4(IF_ID_pc4), .IF_ID_valid(IF_ID_valid)
   );

   // Advance the model from the inputs seen before the edge, then clock.
   task automatic cyc();
      bit redir;
      redir = (Branch_taken == 2'b01) || (Branch_taken == 2'b10);
      if (rst) begin
         m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_buf.delete();
      end else if (redir) begin
         m_pc = (Branch_taken == 2'b01) ? br_target : jump_target;
         m_buf.delete();
         if (Flush || !Stall) begin m_instr = 0; m_valid = 0; end
      end else if (Flush) begin
         m_buf.delete(); m_instr = 0; m_valid = 0;
      end else if (m_buf.size() != 0) begin
         if (!Stall) begin
            m_instr = m_buf.pop_front(); m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
         end
      end else if (imem_ready) begin
         if (Stall) m_buf.push_back(mem(m_pc));
         else begin
            m_instr = mem(m_pc); m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
         end
      end else if (!Stall) begin
         m_instr = 0; m_valid = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      Branch_taken = 2'b00; Flush = 0; Stall = 0; imem_ready = 1;
      br_target = 0; jump_target = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle_inputs();
      cyc(); cyc();
      checks++;
      if (PC !== 32'h0 || IF_ID_valid !== 1'b0 || IF_ID_instr !== 32'h0 || IF_ID_pc4 !== 32'h0) begin
         failures++;
         $display("FAIL reset: PC=%h valid=%b instr=%h pc4=%h, want 0/0/0/0", PC, IF_ID_valid, IF_ID_instr, IF_ID_pc4);
      end
      checks++;
      if (imem_req !== 1'b0) begin
         failures++; $display("FAIL reset_req: imem_req=%b want 0", imem_req);
      end
      rst = 0; #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         failures++; $display("FAIL reset_release: req=%b addr=%h want 1/0", imem_req, imem_addr);
      end
   endtask

   task automatic test_sequential();
      for (int i = 1; i <= 3; i++) begin
         cyc();
         checks++;
         if (PC !== 32'(i*4) || IF_ID_pc4 !== 32'(i*4) || IF_ID_valid !== 1'b1 ||
             IF_ID_instr !== mem(32'((i-1)*4))) begin
            failures++;
            $display("FAIL seq%0d: PC=%h pc4=%h valid=%b instr=%h want %h/%h/1/%h", i, PC,
                     IF_ID_pc4, IF_ID_valid, IF_ID_instr, 32'(i*4), 32'(i*4), mem(32'((i-1)*4)));
         end
      end
   endtask

   task automatic test_redirect_flush();
      Branch_taken = 2'b10; jump_target = 32'h40; Flush = 1;
      cyc();
      Branch_taken = 2'b01; br_target = 32'h100; Flush = 1;
      checks++;
      if (PC !== 32'h40) begin failures++; $display("FAIL jump_to_40: PC=%h want 40", PC); end
      cyc();
      idle_inputs();
      checks++;
      if (PC !== 32'h100 || IF_ID_valid !== 1'b0 || IF_ID_instr !== 32'h0) begin
         failures++;
         $display("FAIL br_flush: PC=%h valid=%b instr=%h want 100/0/0", PC, IF_ID_valid, IF_ID_instr);
      end
      cyc();
      checks++;
      if (IF_ID_instr !== mem(32'h100) || IF_ID_pc4 !== 32'h104 || IF_ID_valid !== 1'b1) begin
         failures++;
         $display("FAIL br_target_fetch: instr=%h pc4=%h valid=%b want %h/104/1", IF_ID_instr, IF_ID_pc4,
                  IF_ID_valid, mem(32'h100));
      end
   endtask

   task automatic test_stall_hold();
      logic [31:0] old_instr;
      Branch_taken = 2'b10; jump_target = 32'h20; Flush = 1;
      cyc();
      idle_inputs(); Stall = 1;
      old_instr = IF_ID_instr;
      cyc();
      checks++;
      if (imem_req !== 1'b0 || PC !== 32'h20 || IF_ID_instr !== old_instr) begin
         failures++;
         $display("FAIL stall_hold: req=%b PC=%h instr=%h want 0/20/%h", imem_req, PC, IF_ID_instr, old_instr);
      end
      cyc(); cyc();
      Stall = 0;
      cyc();
      checks++;
      if (IF_ID_instr !== mem(32'h20) || IF_ID_pc4 !== 32'h24 || PC !== 32'h24 || IF_ID_valid !== 1'b1) begin
         failures++;
         $display("FAIL stall_release: instr=%h pc4=%h PC=%h valid=%b want %h/24/24/1", IF_ID_instr,
                  IF_ID_pc4, PC, IF_ID_valid, mem(32'h20));
      end
   endtask

   task automatic test_not_ready();
      Branch_taken = 2'b01; br_target = 32'h8; Flush = 1;
      cyc();
      idle_inputs(); imem_ready = 0;
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++;
         if (IF_ID_valid !== 1'b0 || IF_ID_instr !== 32'h0 || PC !== 32'h8 || imem_addr !== 32'h8) begin
            failures++;
            $display("FAIL bubble%0d: valid=%b instr=%h PC=%h addr=%h want 0/0/8/8", i, IF_ID_valid,
                     IF_ID_instr, PC, imem_addr);
         end
      end
      imem_ready = 1;
      cyc();
      checks++;
      if (IF_ID_instr !== mem(32'h8) || IF_ID_valid !== 1'b1 || PC !== 32'hC) begin
         failures++;
         $display("FAIL ready_resume: instr=%h valid=%b PC=%h want %h/1/c", IF_ID_instr, IF_ID_valid, PC, mem(32'h8));
      end
   endtask

   task automatic test_hold_jump();
      Stall = 1;
      cyc();
      Branch_taken = 2'b10; jump_target = 32'h200; Flush = 1;
      cyc();
      idle_inputs();
      checks++;
      if (PC !== 32'h200 || IF_ID_valid !== 1'b0 || imem_req !== 1'b1) begin
         failures++;
         $display("FAIL hold_jump: PC=%h valid=%b req=%b want 200/0/1", PC, IF_ID_valid, imem_req);
      end
      cyc();
      checks++;
      if (IF_ID_instr !== mem(32'h200) || IF_ID_pc4 !== 32'h204) begin
         failures++;
         $display("FAIL hold_jump_ibuf: instr=%h pc4=%h want %h/204", IF_ID_instr, IF_ID_pc4, mem(32'h200));
      end
   endtask

   task automatic test_wrap_and_reset();
      Branch_taken = 2'b10; jump_target = 32'hFFFF_FFFC; Flush = 1;
      cyc();
      idle_inputs();
      cyc();
      checks++;
      if (PC !== 32'h0 || IF_ID_pc4 !== 32'h0 || IF_ID_instr !== mem(32'hFFFF_FFFC)) begin
         failures++;
         $display("FAIL wrap: PC=%h pc4=%h instr=%h want 0/0/%h", PC, IF_ID_pc4, IF_ID_instr, mem(32'hFFFF_FFFC));
      end
      cyc(); cyc();
      Stall = 1;
      cyc(); cyc();
      rst = 1;
      cyc();
      checks++;
      if (PC !== 32'h0 || IF_ID_valid !== 1'b0 || imem_req !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_hold: PC=%h valid=%b req=%b want 0/0/0", PC, IF_ID_valid, imem_req);
      end
      rst = 0; Stall = 0;
      cyc();
      checks++;
      if (IF_ID_instr !== mem(32'h0) || PC !== 32'h4 || IF_ID_valid !== 1'b1) begin
         failures++;
         $display("FAIL after_reset_fetch: instr=%h PC=%h valid=%b want %h/4/1", IF_ID_instr, PC,
                  IF_ID_valid, mem(32'h0));
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst          = ($urandom_range(0, 59) == 0);
         Branch_taken = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         Flush        = ($urandom_range(0, 9) == 0);
         Stall        = ($urandom_range(0, 3) == 0);
         imem_ready   = ($urandom_range(0, 4) != 0);
         br_target    = $urandom() & 32'hFFFF_FFFC;
         jump_target  = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 19) == 0) jump_target = 32'hFFFF_FFF8;
         #1;
         checks++;
         if (imem_req !== (!rst && m_buf.size() == 0) || imem_addr !== m_pc) begin
            failures++;
            $display("FAIL rnd_req%0d: req=%b addr=%h want %b/%h", n, imem_req, imem_addr,
                     (!rst && m_buf.size() == 0), m_pc);
         end
         cyc();
         checks++;
         if (PC !== m_pc || IF_ID_instr !== m_instr || IF_ID_pc4 !== m_pc4 || IF_ID_valid !== m_valid) begin
            failures++;
            $display("FAIL rnd%0d: PC=%h instr=%h pc4=%h valid=%b want %h/%h/%h/%b", n, PC, IF_ID_instr,
                     IF_ID_pc4, IF_ID_valid, m_pc, m_instr, m_pc4, m_valid);
         end
      end
      rst = 0;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_redirect_flush();
      test_stall_hold();
      test_not_ready();
      test_hold_jump();
      test_wrap_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
